// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus of the MEM-stage access unit.
// slave = access unit side, master = pipeline/memory environment side.
interface mem_access_unit_if;
  logic        i_valid;
  logic        i_load;
  logic        i_store;
  logic [1:0]  i_size;
  logic        i_signed;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_fault;
  logic        o_Memread;
  logic        o_MemWrite;
  logic [31:0] o_address;
  logic [31:0] o_writeData;
  logic [31:0] i_readData;

  modport slave (
    input  i_valid, i_load, i_store, i_size,
    input  i_signed, i_addr, i_wdata, i_readData,
    output o_stall, o_rdata, o_rvalid, o_fault,
    output o_Memread, o_MemWrite, o_address, o_writeData
  );

  modport master (
    output i_valid, i_load, i_store, i_size,
    output i_signed, i_addr, i_wdata, i_readData,
    input  o_stall, o_rdata, o_rvalid, o_fault,
    input  o_Memread, o_MemWrite, o_address, o_writeData
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-addressed data memory.
// Sub-word stores are done as a read-modify-write over two cycles.
module mem_access_unit #(
  parameter int ADDR_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_access_unit_if.slave   bus
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_fault;
  logic [31:0]       r_word;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_lane;
  logic [1:0]        r_size;

  logic [ADDR_W-1:0] w_idx;
  logic              w_hi_bad;
  logic              w_misalign;
  logic              w_req;
  logic              w_ok;
  logic              w_fault;
  logic              w_ld;
  logic              w_st;
  logic              w_st_word;
  logic              w_st_sub;
  logic [4:0]        w_sh_amt;
  logic [31:0]       w_sh;
  logic [31:0]       w_ext;
  logic [4:0]        w_rsh;
  logic [31:0]       w_mask;
  logic [31:0]       w_merge;
  logic              w_rd;
  logic              w_wr;
  logic              w_stall;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdat;

  assign w_idx    = bus.i_addr[ADDR_W+1:2];
  assign w_hi_bad = |bus.i_addr[31:ADDR_W+2];

  // Alignment rule per access size; size 11 is always illegal.
  always_comb begin
    w_misalign = 1'b1;
    case (bus.i_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = bus.i_addr[0];
      2'b10:   w_misalign = |bus.i_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_req     = bus.i_valid && (r_state == IDLE) && !i_rst;
  assign w_ok      = w_req && !w_misalign && !w_hi_bad;
  assign w_fault   = w_req && (bus.i_load || bus.i_store) &&
                     (w_misalign || w_hi_bad ||
                      (bus.i_load && bus.i_store));
  assign w_ld      = w_ok && bus.i_load && !bus.i_store;
  assign w_st      = w_ok && bus.i_store && !bus.i_load;
  assign w_st_word = w_st && (bus.i_size == 2'b10);
  assign w_st_sub  = w_st && (bus.i_size != 2'b10);

  // Lane select: aligned half/word accesses share the byte shift.
  assign w_sh_amt = {bus.i_addr[1:0], 3'b000};
  assign w_sh     = bus.i_readData >> w_sh_amt;

  // Extend the selected lane to 32 bits.
  always_comb begin
    w_ext = w_sh;
    case (bus.i_size)
      2'b00:
        w_ext = {{24{bus.i_signed & w_sh[7]}}, w_sh[7:0]};
      2'b01:
        w_ext = {{16{bus.i_signed & w_sh[15]}}, w_sh[15:0]};
      default:
        w_ext = w_sh;
    endcase
  end

  // Replace the latched lane(s) of the old word with new data.
  assign w_rsh   = {r_lane, 3'b000};
  assign w_mask  = ((r_size == 2'b00) ? 32'h0000_00FF
                                      : 32'h0000_FFFF) << w_rsh;
  assign w_merge = (r_word & ~w_mask) |
                   ((r_wdata << w_rsh) & w_mask);

  // Next-state and memory-side outputs.
  always_comb begin
    w_next  = r_state;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_stall = 1'b0;
    w_addr  = 32'h0;
    w_wdat  = 32'h0;
    if (i_rst) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ld) begin
            w_rd   = 1'b1;
            w_addr = {{(32-ADDR_W){1'b0}}, w_idx};
          end else if (w_st_word) begin
            w_wr   = 1'b1;
            w_addr = {{(32-ADDR_W){1'b0}}, w_idx};
            w_wdat = bus.i_wdata;
          end else if (w_st_sub) begin
            w_rd    = 1'b1;
            w_stall = 1'b1;
            w_addr  = {{(32-ADDR_W){1'b0}}, w_idx};
            w_next  = RMW_WR;
          end
        end
        RMW_WR: begin
          w_wr   = 1'b1;
          w_addr = {{(32-ADDR_W){1'b0}}, r_idx};
          w_wdat = w_merge;
          w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // State, pulses, load result and RMW capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_rdata  <= 32'h0;
      r_rvalid <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= w_ld;
      r_fault  <= w_fault;
      if (w_ld) r_rdata <= w_ext;
    end
  end

  // Old word and request fields for the write half of RMW.
  always_ff @(posedge i_clk) begin
    if (w_st_sub) begin
      r_word  <= bus.i_readData;
      r_idx   <= w_idx;
      r_lane  <= bus.i_addr[1:0];
      r_size  <= bus.i_size;
      r_wdata <= bus.i_wdata;
    end
  end

  assign bus.o_stall     = w_stall;
  assign bus.o_Memread   = w_rd;
  assign bus.o_MemWrite  = w_wr;
  assign bus.o_address   = w_addr;
  assign bus.o_writeData = w_wdat;
  assign bus.o_rdata     = r_rdata;
  assign bus.o_rvalid    = r_rvalid;
  assign bus.o_fault     = r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory model,
// directed scenarios followed by random load/store traffic.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  mem_access_unit_if bus ();

  mem_access_unit #(.ADDR_W(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  logic [7:0]  refb [128];
  int total = 0;
  int bad = 0;
  logic [31:0] exp_rdata;

  assign bus.i_readData = mem[bus.o_address[4:0]];

  always @(negedge clk)
    if (bus.o_MemWrite) mem[bus.o_address[4:0]] <= bus.o_writeData;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {refb[4*idx+3], refb[4*idx+2], refb[4*idx+1], refb[4*idx]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz,
                                           input logic sg,
                                           input logic [31:0] a);
    int n;
    longint unsigned v;
    n = 1 << sz;
    v = 0;
    for (int k = 0; k < n; k++)
      v = v | (longint'(refb[a+k]) << (8*k));
    if (sg && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    for (int k = 0; k < (1 << sz); k++)
      refb[a+k] = wd[8*k +: 8];
  endtask

  task automatic drive(input logic v, input logic ld, input logic st,
                       input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.i_valid  = v;
    bus.i_load   = ld;
    bus.i_store  = st;
    bus.i_size   = sz;
    bus.i_signed = sg;
    bus.i_addr   = a;
    bus.i_wdata  = wd;
  endtask

  task automatic comb_chk(input string t, input logic st, input logic rd,
                          input logic wr, input logic [31:0] ad);
    chk({t, ".stall"}, {31'b0, bus.o_stall}, {31'b0, st});
    chk({t, ".rd"}, {31'b0, bus.o_Memread}, {31'b0, rd});
    chk({t, ".wr"}, {31'b0, bus.o_MemWrite}, {31'b0, wr});
    chk({t, ".addr"}, bus.o_address, ad);
  endtask

  task automatic reg_chk(input string t, input logic rv, input logic fl);
    chk({t, ".rvalid"}, {31'b0, bus.o_rvalid}, {31'b0, rv});
    chk({t, ".fault"}, {31'b0, bus.o_fault}, {31'b0, fl});
    chk({t, ".rdata"}, bus.o_rdata, exp_rdata);
  endtask

  // One request, held by upstream until it retires.
  task automatic op(input string t, input logic ld, input logic st,
                    input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] wd);
    logic mis, oor, act, flt, isld, iswst, issub;
    logic [31:0] ix;
    mis   = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
            (sz == 2'd2 && a[1:0] != 2'd0);
    oor   = (a >= 32'd128);
    act   = ld || st;
    flt   = act && (mis || oor || (ld && st));
    isld  = act && !flt && ld;
    iswst = act && !flt && st && sz == 2'd2;
    issub = act && !flt && st && sz != 2'd2;
    ix    = {27'b0, a[6:2]};
    drive(1'b1, ld, st, sz, sg, a, wd);
    @(negedge clk);
    if (isld) comb_chk(t, 1'b0, 1'b1, 1'b0, ix);
    else if (iswst) begin
      comb_chk(t, 1'b0, 1'b0, 1'b1, ix);
      chk({t, ".wdata"}, bus.o_writeData, wd);
      ref_store(sz, a, wd);
    end else if (issub) comb_chk(t, 1'b1, 1'b1, 1'b0, ix);
    else comb_chk(t, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    if (isld) exp_rdata = ref_load(sz, sg, a);
    reg_chk(t, isld, flt);
    if (issub) begin
      @(negedge clk);
      ref_store(sz, a, wd);
      comb_chk({t, ".w"}, 1'b0, 1'b0, 1'b1, ix);
      chk({t, ".wdata"}, bus.o_writeData, ref_word(a[6:2]));
      @(posedge clk); #1;
      reg_chk({t, ".w"}, 1'b0, 1'b0);
    end
    if (iswst || issub)
      chk({t, ".mem"}, mem[a[6:2]], ref_word(a[6:2]));
  endtask

  task automatic idle(input string t);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    comb_chk(t, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    reg_chk(t, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [1:0] sz;
    int r;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    for (int i = 0; i < 128; i++) refb[i] = 8'h0;
    exp_rdata = 32'h0;
    drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    comb_chk("rst", 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reg_chk("rst", 1'b0, 1'b0);
    rst = 1'b0;
    idle("idle0");

    op("st_w", 1'b0, 1'b1, 2'd2, 1'b1, 32'h10, 32'h1122_3344);
    op("ld_w", 1'b1, 1'b0, 2'd2, 1'b1, 32'h10, 32'h0);
    chk("ld_w.const", bus.o_rdata, 32'h1122_3344);
    op("st_b", 1'b0, 1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AB);
    chk("st_b.const", mem[4], 32'h11AB_3344);
    op("ld_w2", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("ld_w2.const", bus.o_rdata, 32'h11AB_3344);
    op("st_b80", 1'b0, 1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFF_FF80);
    op("ld_bs", 1'b1, 1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
    chk("ld_bs.const", bus.o_rdata, 32'hFFFF_FF80);
    op("ld_bu", 1'b1, 1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
    chk("ld_bu.const", bus.o_rdata, 32'h0000_0080);
    op("ld_hu", 1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    chk("ld_hu.const", bus.o_rdata, 32'h0000_1180);
    op("st_h", 1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_BEEF);
    op("ld_hs", 1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    chk("ld_hs.const", bus.o_rdata, 32'hFFFF_BEEF);
    op("f_h13", 1'b0, 1'b1, 2'd1, 1'b0, 32'h13, 32'h55);
    op("f_w0e", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0E, 32'h0);
    op("f_oor", 1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    op("f_sz3", 1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    op("f_both", 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
    op("nop", 1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    // Reset in the write half of a byte store abandons the write.
    drive(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0077);
    @(negedge clk);
    comb_chk("rmw_rst.r", 1'b1, 1'b1, 1'b0, 32'h4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    comb_chk("rmw_rst.w", 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    exp_rdata = 32'h0;
    reg_chk("rmw_rst", 1'b0, 1'b0);
    rst = 1'b0;
    chk("rmw_rst.mem", mem[4], ref_word(4));
    op("rmw_rst.ld", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("rmw_rst.ldc", bus.o_rdata, 32'h1180_3344);

    // Back-to-back: load, byte store, load with valid held throughout.
    op("b2b.ld", 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    op("b2b.st", 1'b0, 1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_005A);
    op("b2b.ld2", 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("b2b.const", bus.o_rdata, 32'h0000_5A00);

    for (int i = 0; i < 80; i++) begin
      r  = int'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
      a  = ($urandom_range(0, 9) == 0) ? $urandom
                                       : 32'($urandom_range(0, 127));
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      wd = $urandom;
      if (r < 4)       op("rnd.ld", 1'b1, 1'b0, sz, 1'($urandom), a, wd);
      else if (r < 8)  op("rnd.st", 1'b0, 1'b1, sz, 1'b0, a, wd);
      else if (r == 8) op("rnd.both", 1'b1, 1'b1, sz, 1'b0, a, wd);
      else             idle("rnd.idle");
    end
    for (int i = 0; i < 32; i++)
      chk("final.mem", mem[i], ref_word(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Pipeline-side initiator for the word-addressed data memory; sits in the MEM stage between the EX/MEM register and the data memory.
- Converts byte, halfword and word loads/stores on byte addresses into word-index memory accesses.
- Performs sub-word stores as a 2-cycle read-modify-write, because the memory only writes whole words.
- Sign- or zero-extends load data, and flags misaligned or out-of-range accesses.

Parameters:
- ADDR_W, 5, width of the memory word index (memory depth = 2^ADDR_W words).

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  request present from EX/MEM.
- i_load  in  1  request is a load.
- i_store  in  1  request is a store.
- i_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- i_signed  in  1  loads: 1 sign-extend, 0 zero-extend.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-justified.
- o_stall  out  1  upstream must hold its request this cycle.
- o_rdata  out  32  registered, extended load result.
- o_rvalid  out  1  one-cycle pulse: o_rdata updated.
- o_fault  out  1  one-cycle pulse: request rejected.
- o_Memread  out  1  memory read enable.
- o_MemWrite  out  1  memory write enable (memory commits on negedge of the same cycle).
- o_address  out  32  word index, zero-extended above ADDR_W bits.
- o_writeData  out  32  word to memory.
- i_readData  in  32  memory read data, combinational from o_address.

Behaviour:
- Lane mapping is little-endian: byte lane k = i_addr[1:0] occupies bits 8k+7:8k; half lane uses i_addr[1] (0 = bits 15:0).
- Word index = i_addr[ADDR_W+1:2].
- Fault conditions, checked in IDLE:
  - i_size = 11;
  - half with i_addr[0] = 1;
  - word with i_addr[1:0] != 0;
  - i_addr[31:ADDR_W+2] != 0;
  - i_load and i_store both 1.
- On a fault: no memory enable, o_fault = 1 next cycle, 1-cycle occupancy, o_stall = 0.
- Valid request with neither i_load nor i_store set: no-op, no pulse.
- FSM states are IDLE and RMW_WR.
- IDLE, load:
  - o_Memread = 1 in this cycle;
  - at posedge, o_rdata <= selected lane extended to 32 bits, o_rvalid <= 1;
  - o_stall = 0; latency 1 cycle.
- IDLE, word store: o_MemWrite = 1, o_writeData = i_wdata, o_stall = 0; single cycle.
- IDLE, byte/half store:
  - this cycle drive o_Memread = 1, o_stall = 1;
  - at posedge latch i_readData, word index, lane, size and i_wdata, then go to RMW_WR.
- RMW_WR:
  - o_MemWrite = 1, o_address = latched index;
  - o_writeData = latched word with the target lane(s) replaced by i_wdata[7:0] or [15:0];
  - o_stall = 0; i_* are ignored because upstream still holds the same request;
  - return to IDLE at posedge, where upstream retires the request.
- o_Memread and o_MemWrite are never both 1 in the same cycle.
- Idle outputs: o_address = 0, o_writeData = 0, enables = 0.
- o_rvalid and o_fault are single-cycle pulses, cleared in any cycle with no new event.
- o_rdata holds its value between loads.
- Reset (synchronous, any state):
  - state <= IDLE, o_rdata <= 0, o_rvalid <= 0, o_fault <= 0;
  - while i_rst = 1, o_Memread, o_MemWrite and o_stall are forced to 0;
  - a reset asserted in RMW_WR abandons the write: the memory is not modified.
- Back-to-back: a new request may be accepted in the cycle after a load, a word store, a fault or RMW_WR.
- A load immediately following a store to the same word returns the new data, because the write lands at negedge before the next cycle's read.

Test Plan:
- Word store 0x11223344 to addr 0x10, then signed word load from 0x10 -> o_Memread and o_address = 4; one cycle later o_rvalid = 1, o_rdata = 0x11223344.
- Byte store 0xAB to addr 0x12 over that word -> cycle 1: o_stall = 1, o_Memread = 1; cycle 2: o_MemWrite = 1, o_writeData = 0x11AB3344; a word reload returns 0x11AB3344.
- Byte load from 0x12 with i_signed = 1 after storing 0x80 -> o_rdata = 0xFFFFFF80; same load with i_signed = 0 -> 0x00000080; half load from 0x12 -> lane bits 31:16 extended.
- Half store at 0x13, word load at 0x0E, and load at 0x80 (out of range for ADDR_W = 5) -> each gives o_fault pulse = 1, no Memread/MemWrite, o_rvalid = 0.
- Byte store with i_rst asserted during RMW_WR -> o_MemWrite = 0 that cycle, memory word unchanged, state IDLE, all registered outputs 0.
- Load, byte store and load issued back-to-back with i_valid held -> o_stall high exactly one cycle, total 4 cycles, both o_rvalid pulses carry the correct data.
